// File: rtl/dm_lane_unit.sv
// Data-memory lane unit: combinational store lane alignment and registered load extraction.
// Optional alignment checking is enabled with the DM_ALIGN_CHECK_EN macro.
module dm_lane_unit #(
    parameter int TYPE_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TYPE_W-1:0] dm_type,
    input  logic [1:0]        addr_low,
    input  logic              we,
    input  logic              re,
    input  logic [31:0]       wd,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic [31:0]       rd,
    output logic              rd_valid
`ifdef DM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam logic [TYPE_W-1:0] T_WORD   = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] T_HALF_S = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_HALF_U = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_BYTE_S = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] T_BYTE_U = TYPE_W'(4);

    logic        is_word;
    logic        is_half;
    logic        is_byte;
    logic        is_signed;
    logic        mis;
    logic        capture;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_ext;

    assign is_word   = (dm_type == T_WORD);
    assign is_half   = (dm_type == T_HALF_S) || (dm_type == T_HALF_U);
    assign is_byte   = (dm_type == T_BYTE_S) || (dm_type == T_BYTE_U);
    assign is_signed = (dm_type == T_HALF_S) || (dm_type == T_BYTE_S);

`ifdef DM_ALIGN_CHECK_EN
    assign mis      = (is_half && addr_low[0]) || (is_word && (addr_low != 2'b00));
    assign misalign = mis;
`else
    assign mis = 1'b0;
`endif

    // Store path: replicate the data across all lanes, enables pick the target lanes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_wdata = '0;
        mem_be    = '0;
        if (we && !mis) begin
            if (is_word) begin
                mem_wdata = wd;
                mem_be    = 4'b1111;
            end else if (is_half) begin
                mem_wdata = {2{wd[15:0]}};
                mem_be    = addr_low[1] ? 4'b1100 : 4'b0011;
            end else if (is_byte) begin
                mem_wdata = {4{wd[7:0]}};
                mem_be    = 4'b0001 << addr_low;
            end
        end
    end

    // Load path: select the addressed lane, then sign- or zero-extend.
    always_comb begin
        half_sel = addr_low[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = mem_rdata[{addr_low, 3'b000} +: 8];
        if (is_word) begin
            load_ext = mem_rdata;
        end else if (is_half) begin
            load_ext = {{16{is_signed && half_sel[15]}}, half_sel};
        end else begin
            load_ext = {{24{is_signed && byte_sel[7]}}, byte_sel};
        end
    end

    assign capture = re && (is_word || is_half || is_byte) && !mis;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd       <= '0;
            rd_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep register updates order-independent.
            rd_valid <= capture;
            if (capture) begin
                rd <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_dm_lane_unit.sv
// Self-checking bench for dm_lane_unit: directed cases plus randomized traffic against a byte-level model.
// Honours DM_ALIGN_CHECK_EN the same way as the design.
module tb_dm_lane_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  dm_type;
    logic [1:0]  addr_low;
    logic        we;
    logic        re;
    logic [31:0] wd;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] rd;
    logic        rd_valid;
`ifdef DM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_rd;
    logic        exp_valid;

    dm_lane_unit #(.TYPE_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .dm_type   (dm_type),
        .addr_low  (addr_low),
        .we        (we),
        .re        (re),
        .wd        (wd),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .rd        (rd),
        .rd_valid  (rd_valid)
`ifdef DM_ALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Access size in bytes; 0 means the code performs no access.
    function automatic int size_of(input int t);
        case (t)
            0:       return 4;
            1, 2:    return 2;
            3, 4:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_mis(input int t, input int a);
`ifdef DM_ALIGN_CHECK_EN
        int sz = size_of(t);
        return (sz > 1) && ((a % sz) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] model_be(input int t, input int a, input bit w);
        int sz = size_of(t);
        int off;
        if (!w || sz == 0 || model_mis(t, a)) return 4'b0000;
        off = a - (a % sz);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input int t, input int a, input bit w, input logic [31:0] d);
        int sz = size_of(t);
        logic [31:0] r = '0;
        if (model_be(t, a, w) == 4'b0000) return '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input int t, input int a, input logic [31:0] m);
        int sz = size_of(t);
        int bits = 8 * sz;
        int off = a - (a % sz);
        longint v = longint'(m) >> (8 * off);
        v = v & ((64'd1 << bits) - 1);
        if ((t == 1 || t == 3) && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // One cycle: drive at negedge, check store path, clock, update model, check load path.
    task automatic do_cycle(input int t, input int a, input bit w, input bit r,
                            input logic [31:0] d, input logic [31:0] m);
        @(negedge clk);
        dm_type   = 6'(t);
        addr_low  = 2'(a);
        we        = w;
        re        = r;
        wd        = d;
        mem_rdata = m;
        #1;
        check("mem_be", 32'(mem_be), 32'(model_be(t, a, w)));
        check("mem_wdata", mem_wdata, model_wdata(t, a, w, d));
`ifdef DM_ALIGN_CHECK_EN
        check("misalign", 32'(misalign), 32'(model_mis(t, a)));
`endif
        @(posedge clk);
        if (r && size_of(t) != 0 && !model_mis(t, a)) begin
            exp_rd    = model_load(t, a, m);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check("rd", rd, exp_rd);
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        exp_rd    = '0;
        exp_valid = 1'b0;
        check("rst_rd", rd, 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        dm_type   = '0;
        addr_low  = '0;
        we        = 1'b0;
        re        = 1'b0;
        wd        = '0;
        mem_rdata = '0;
        exp_rd    = '0;
        exp_valid = 1'b0;
        #2;
        check("reset_rd", rd, 32'h0);
        check("reset_valid", 32'(rd_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases with hand-derived values.
        do_cycle(3, 1, 1'b1, 1'b0, 32'h0000_00A5, 32'h0);
        check("byte_store_be", 32'(mem_be), 32'h2);
        check("byte_store_wd", mem_wdata, 32'hA5A5_A5A5);
        do_cycle(1, 2, 1'b1, 1'b0, 32'h1234_BEEF, 32'h0);
        check("half_store_be", 32'(mem_be), 32'hC);
        check("half_store_wd", mem_wdata, 32'hBEEF_BEEF);
        do_cycle(3, 3, 1'b0, 1'b1, 32'h0, 32'h80FF_0000);
        check("lb_sext", rd, 32'hFFFF_FF80);
        do_cycle(2, 2, 1'b0, 1'b1, 32'h0, 32'h8001_7777);
        check("lhu", rd, 32'h0000_8001);
        do_cycle(1, 2, 1'b0, 1'b1, 32'h0, 32'h8001_7777);
        check("lh", rd, 32'hFFFF_8001);
        do_cycle(0, 0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h1357_9BDF);
        do_cycle(7, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h2468_ACE0);
        check("undef_hold", rd, 32'h1357_9BDF);
        do_cycle(0, 1, 1'b1, 1'b1, 32'h1111_2222, 32'hA5A5_0F0F);
`ifdef DM_ALIGN_CHECK_EN
        check("word_mis_be", 32'(mem_be), 32'h0);
        check("word_mis_flag", 32'(misalign), 32'h1);
`endif

        // Capture, reset between edges, then idle: rd must stay 0.
        do_cycle(4, 1, 1'b0, 1'b1, 32'h0, 32'h0000_7F00);
        check("lbu_pre_reset", rd, 32'h0000_007F);
        pulse_reset();
        do_cycle(0, 0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        check("post_reset_hold", rd, 32'h0);

        // Randomized traffic, mostly defined codes, occasional reset.
        for (int i = 0; i < 400; i++) begin
            int t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 63)) : int'($urandom_range(0, 4));
            do_cycle(t, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 29) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_lane_unit.md
DM_LANE_UNIT -- requirements
Module: dm_lane_unit

Interface
REQ-001 SHALL have parameter TYPE_W, default 6, width of the access-type code.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL have port dm_type, input, TYPE_W: access type. 0=word, 1=signed half, 2=unsigned half, 3=signed byte, 4=unsigned byte, other=no access.
REQ-005 SHALL have port addr_low, input, 2, byte address bits [1:0].
REQ-006 SHALL have port we, input, 1, store request.
REQ-007 SHALL have port re, input, 1, load request.
REQ-008 SHALL have port wd, input, 32, store data from the register file (right-aligned).
REQ-009 SHALL have port mem_rdata, input, 32, addressed memory word.
REQ-010 SHALL have port mem_wdata, output, 32, lane-aligned store data.
REQ-011 SHALL have port mem_be, output, 4, byte write enables; bit i covers bits [8i+7:8i].
REQ-012 SHALL have port rd, output, 32, registered extended load result.
REQ-013 SHALL have port rd_valid, output, 1, registered, high for one cycle after a captured load.

Function
REQ-014 Store path SHALL be combinational from dm_type, addr_low, we and wd.
REQ-015 Word store: mem_wdata=wd, mem_be=4'b1111.
REQ-016 Half store (type 1 or 2): mem_wdata={wd[15:0],wd[15:0]}; mem_be=4'b1100 if addr_low[1]=1, else 4'b0011; addr_low[0] ignored.
REQ-017 Byte store (type 3 or 4): mem_wdata=wd[7:0] replicated four times; mem_be=one-hot 1<<addr_low.
REQ-018 mem_be SHALL be 4'b0000 when we=0 or dm_type is an undefined code; mem_wdata is then don't-care but SHALL be 0.
REQ-019 Load extraction: word returns mem_rdata; half selects [31:16] if addr_low[1]=1 else [15:0]; byte selects [8*addr_low+7:8*addr_low].
REQ-020 Types 1 and 3 SHALL sign-extend to 32 bits; types 2 and 4 SHALL zero-extend.
REQ-021 At the rising clk edge with re=1 and a defined dm_type, rd SHALL load the extracted value and rd_valid SHALL be 1 in the next cycle (latency 1).
REQ-022 With re=0 or an undefined dm_type, rd SHALL hold its value and rd_valid SHALL go 0.
REQ-023 we and re both high SHALL be legal; both paths operate independently in the same cycle.

Reset
REQ-024 While reset=0, rd SHALL be 32'h0 and rd_valid 0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL discard the pending load; the first capture occurs at the first rising edge after reset=1.
REQ-026 Combinational store outputs SHALL not depend on reset.

Configuration
REQ-027 Macro DM_ALIGN_CHECK_EN: when defined, output misalign (1 bit, combinational) SHALL be 1 for a half access with addr_low[0]=1 or a word access with addr_low!=0; mem_be SHALL then be 0 and a misaligned load SHALL not update rd or assert rd_valid.
REQ-028 Without DM_ALIGN_CHECK_EN: no misalign port; low address bits below the access size are ignored as in REQ-016/REQ-019.

Verification
REQ-029 Byte store type 3, addr_low=01, wd=32'h0000_00A5, we=1 -> mem_be=4'b0010, mem_wdata=32'hA5A5A5A5.
REQ-030 Half store type 1, addr_low=10, wd=32'h1234_BEEF -> mem_be=4'b1100, mem_wdata=32'hBEEFBEEF.
REQ-031 Load type 3, addr_low=11, mem_rdata=32'h80FF_0000, re=1 -> after one edge rd=32'hFFFFFF80, rd_valid=1.
REQ-032 Load type 2, addr_low=10, mem_rdata=32'h8001_7777 -> rd=32'h0000_8001; type 1 same input -> rd=32'hFFFF_8001.
REQ-033 Load captured, then reset=0 between edges -> rd=0, rd_valid=0 immediately; re=0 afterwards -> rd holds 0.
REQ-034 With DM_ALIGN_CHECK_EN, word store addr_low=01, we=1 -> misalign=1, mem_be=4'b0000.
